// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Sorts presses of a debounced, synchronous button into short, long and
// (optionally) double presses. The duration counter counts consecutive
// samples of the current level, so the decisions line up with sample counts:
//   - LONG_CYCLES high samples in a row give a long press. OUTLONG fires while
//     the button is still held.
//   - An earlier release gives a short press. With double-press detection on,
//     a second press that starts inside the gap window gives a double press.
//
// Optional feature macro: BTN_DOUBLE_PRESS_EN
//   defined   : adds the WAITGAP/SECOND states. OUTSHORT is held back until
//               GAP_CYCLES low samples have closed the double-press window.
//   undefined : OUTSHORT fires in the cycle after the release edge, and
//               OUTDOUBLE is tied low.
//
// Parameters
//   CNT_W       width of the duration counter
//   LONG_CYCLES high samples that classify a long press   (2 .. 2^CNT_W-1)
//   GAP_CYCLES  low samples that close the double window  (2 .. 2^CNT_W-1)
//
// Ports
//   IPTCLK    in   clock; all state changes on its rising edge
//   IPTRST    in   asynchronous, active-high reset
//   IPTBTN    in   debounced button level, 1 = pressed
//   OUTSHORT  out  one-cycle pulse, short press
//   OUTLONG   out  one-cycle pulse, long press
//   OUTDOUBLE out  one-cycle pulse, double press (always 0 without the macro)
//   OUTBUSY   out  level, high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module button_press_classifier #(
  parameter int CNT_W       = 16,
  parameter int LONG_CYCLES = 50000,
  parameter int GAP_CYCLES  = 20000
) (
  input  logic IPTCLK,
  input  logic IPTRST,
  input  logic IPTBTN,
  output logic OUTSHORT,
  output logic OUTLONG,
  output logic OUTDOUBLE,
  output logic OUTBUSY
);

  // Stop elaboration if a threshold does not fit the counter. If it did not
  // fit, the terminal compare could never match and the counter would wrap.
  if (LONG_CYCLES < 2 || LONG_CYCLES > (2**CNT_W) - 1) begin : g_long_chk
    $error("LONG_CYCLES out of range for CNT_W");
  end
  if (GAP_CYCLES < 2 || GAP_CYCLES > (2**CNT_W) - 1) begin : g_gap_chk
    $error("GAP_CYCLES out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONGHELD
`ifdef BTN_DOUBLE_PRESS_EN
    ,
    ST_WAITGAP,
    ST_SECOND
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_DOUBLE_PRESS_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;
`ifdef BTN_DOUBLE_PRESS_EN
  logic             double_q, double_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
`ifdef BTN_DOUBLE_PRESS_EN
    double_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (IPTBTN) begin
          // This edge already sees the first high sample, so the count starts at 1.
          state_d = ST_PRESSED;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (IPTBTN) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_LONGHELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
`ifdef BTN_DOUBLE_PRESS_EN
          // The release edge is the first low sample of the gap window.
          state_d = ST_WAITGAP;
          cnt_d   = CNT_W'(1);
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
`endif
        end
      end
      ST_LONGHELD: begin
        // The long press has already been reported; wait silently for release.
        if (!IPTBTN) begin
          state_d = ST_IDLE;
        end
      end
`ifdef BTN_DOUBLE_PRESS_EN
      ST_WAITGAP: begin
        if (IPTBTN) begin
          state_d = ST_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SECOND: begin
        // A second press is reported as a double press however long it is held.
        if (!IPTBTN) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Busy is computed from the next state so it falls in the same cycle as the pulse.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge IPTCLK or posedge IPTRST) begin
    if (IPTRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BTN_DOUBLE_PRESS_EN
      double_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
`ifdef BTN_DOUBLE_PRESS_EN
      double_q <= double_d;
`endif
    end
  end

  assign OUTSHORT  = short_q;
  assign OUTLONG   = long_q;
  assign OUTBUSY   = busy_q;
`ifdef BTN_DOUBLE_PRESS_EN
  assign OUTDOUBLE = double_q;
`else
  assign OUTDOUBLE = 1'b0;
`endif

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter CNT_W, default 16: width of the internal duration counter.
REQ-002 Parameter LONG_CYCLES, default 50000: number of consecutive high samples that classifies a press as long; legal range 2..2^CNT_W-1.
REQ-003 Parameter GAP_CYCLES, default 20000: number of consecutive low samples that closes the double-press window; legal range 2..2^CNT_W-1.
REQ-004 IPTCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 IPTRST  input  1  reset, asynchronous, active-high.
REQ-006 IPTBTN  input  1  debounced, synchronous button level; 1 = pressed.
REQ-007 OUTSHORT  output  1  one-cycle pulse: short press classified.
REQ-008 OUTLONG  output  1  one-cycle pulse: long press classified.
REQ-009 OUTDOUBLE  output  1  one-cycle pulse: double press classified (macro-dependent).
REQ-010 OUTBUSY  output  1  level: high whenever the state is not IDLE.

Function
REQ-011 States SHALL be IDLE, PRESSED, LONGHELD, WAITGAP, SECOND, and the counter CNT SHALL be CNT_W bits wide.
REQ-012 All outputs SHALL be registered; each pulse SHALL be high for exactly the one cycle following the triggering edge.
REQ-013 IDLE, IPTBTN=1: go to PRESSED with CNT=1. IDLE, IPTBTN=0: hold.
REQ-014 PRESSED, IPTBTN=1, CNT==LONG_CYCLES-1: pulse OUTLONG and go to LONGHELD. Otherwise, with IPTBTN=1, increment CNT.
REQ-015 PRESSED, IPTBTN=0: go to WAITGAP with CNT=1 when the macro is defined, else pulse OUTSHORT and go to IDLE.
REQ-016 LONGHELD SHALL hold while IPTBTN=1 and go to IDLE when IPTBTN=0, with no further pulses and no OUTSHORT.
REQ-017 WAITGAP, IPTBTN=1: go to SECOND. WAITGAP, IPTBTN=0, CNT==GAP_CYCLES-1: pulse OUTSHORT and go to IDLE. Otherwise increment CNT.
REQ-018 SECOND SHALL hold while IPTBTN=1, regardless of duration, and on IPTBTN=0 SHALL pulse OUTDOUBLE and go to IDLE.
REQ-019 Boundary: exactly LONG_CYCLES-1 high samples SHALL give short or double; exactly LONG_CYCLES SHALL give long.
REQ-020 CNT SHALL never wrap; its maximum is max(LONG_CYCLES, GAP_CYCLES)-1.
REQ-021 At most one of OUTSHORT, OUTLONG, OUTDOUBLE SHALL be high in any cycle, and each classified press SHALL produce exactly one pulse.

Reset
REQ-022 IPTRST=1 SHALL immediately force IDLE, CNT=0, and OUTSHORT=OUTLONG=OUTDOUBLE=OUTBUSY=0, independent of IPTCLK.
REQ-023 Reset mid-press SHALL discard the event; after release, the first edge seeing IPTBTN=1 in IDLE SHALL start a fresh press.

Configuration
REQ-024 Macro BTN_DOUBLE_PRESS_EN defined: WAITGAP and SECOND SHALL be implemented, and OUTSHORT SHALL be delayed by the gap window.
REQ-025 Macro undefined: WAITGAP and SECOND SHALL be compiled out, OUTDOUBLE SHALL be tied 0, and OUTSHORT SHALL pulse in the cycle after the release edge.

Verification (LONG_CYCLES=8, GAP_CYCLES=4)
REQ-026 Macro on, press 3 cycles, then release -> one OUTSHORT pulse after the 4th consecutive low sample; OUTBUSY falls in the same cycle.
REQ-027 Hold 12 cycles -> OUTLONG after the 8th high sample; nothing on release; OUTBUSY low one cycle after release.
REQ-028 Macro on, press 2 / release 2 / press 2 / release -> a single OUTDOUBLE after the release edge; no OUTSHORT.
REQ-029 Press for exactly 7 cycles -> short; press for exactly 8 cycles -> long (boundary check).
REQ-030 Assert IPTRST while in PRESSED with CNT=5 -> all outputs 0 asynchronously; after release, a 3-cycle press -> normal OUTSHORT.
REQ-031 Macro off, press 3 cycles, then release -> OUTSHORT in the cycle after the release edge; OUTDOUBLE always 0.
